wb_writer: RTL

- Write-back stage register and load-completion unit for the OpenMIPS32 five-stage pipeline.
- Captures MEM-stage results and drives the regfile write port (we/waddr/wdata).
- Waits for the data-memory read response on loads, then aligns and sign/zero-extends the returned word (big-endian).
- Requests a pipeline stall from ctrl while a load response is outstanding.

---
 rtl/wb_writer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wb_writer.sv
// wb_writer: write-back stage register and load-completion unit.
// Drives the regfile write port, waits on the data-memory response for loads,
// and aligns/extends the returned big-endian word. Requests a stall while a
// load response is outstanding.
// Optional: define WB_LOAD_TIMEOUT_EN to abort a load after TIMEOUT WAIT cycles.
module wb_writer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        mem_wreg_i,
    input  logic [4:0]  mem_wd_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_load_i,
    input  logic [2:0]  mem_ltype_i,
    input  logic [1:0]  mem_lsb_i,
    input  logic        dresp_valid_i,
    input  logic [31:0] dresp_data_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [2:0] LT_LB  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic        we_nxt, misalign_nxt, timeout_nxt;
    logic [4:0]  waddr_nxt;
    logic [31:0] wdata_nxt;
    logic [4:0]  ld_wd, ld_wd_nxt;
    logic [2:0]  ld_type, ld_type_nxt;
    logic [1:0]  ld_lsb, ld_lsb_nxt;

`ifdef WB_LOAD_TIMEOUT_EN
    logic [TO_W-1:0] cnt, cnt_nxt;
`endif

    // Reject a counter that cannot hold TIMEOUT.
    if (TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout_cfg
        $error("wb_writer: TIMEOUT does not fit in TO_W bits");
    end

    // Halfword and word loads must be naturally aligned.
    function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] lsb);
        logic r;
        r = 1'b0;
        if (lt == LT_LH || lt == LT_LHU)      r = lsb[0];
        else if (lt != LT_LB && lt != LT_LBU) r = (lsb != 2'd0);
        return r;
    endfunction

    // Big-endian lane select plus sign/zero extension.
    function automatic logic [31:0] align(input logic [2:0] lt, input logic [1:0] lsb,
                                          input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lsb)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = lsb[1] ? d[15:0] : d[31:16];
        case (lt)
            LT_LB:   r = {{24{b[7]}}, b};
            LT_LBU:  r = {24'd0, b};
            LT_LH:   r = {{16{h[15]}}, h};
            LT_LHU:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // State, latched load info and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= 5'd0;
            wb_wdata_o <= 32'd0;
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            ld_wd      <= 5'd0;
            ld_type    <= 3'd0;
            ld_lsb     <= 2'd0;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            wb_we_o    <= we_nxt;
            wb_waddr_o <= waddr_nxt;
            wb_wdata_o <= wdata_nxt;
            misalign_o <= misalign_nxt;
            timeout_o  <= timeout_nxt;
            ld_wd      <= ld_wd_nxt;
            ld_type    <= ld_type_nxt;
            ld_lsb     <= ld_lsb_nxt;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt        <= cnt_nxt;
`endif
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt    = state;
        we_nxt       = 1'b0;
        waddr_nxt    = wb_waddr_o;
        wdata_nxt    = wb_wdata_o;
        misalign_nxt = 1'b0;
        timeout_nxt  = 1'b0;
        ld_wd_nxt    = ld_wd;
        ld_type_nxt  = ld_type;
        ld_lsb_nxt   = ld_lsb;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_nxt      = cnt;
`endif
        case (state)
            S_IDLE: begin
                if (!(flush_i || stall_i)) begin
                    if (!mem_load_i) begin
                        we_nxt    = mem_wreg_i;
                        waddr_nxt = mem_wd_i;
                        wdata_nxt = mem_wdata_i;
                    end else if (mem_wreg_i) begin
                        ld_wd_nxt   = mem_wd_i;
                        ld_type_nxt = mem_ltype_i;
                        ld_lsb_nxt  = mem_lsb_i;
                        if (is_misaligned(mem_ltype_i, mem_lsb_i)) begin
                            misalign_nxt = 1'b1;
                        end else begin
                            state_nxt = S_WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
                            cnt_nxt   = '0;
`endif
                        end
                    end
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (dresp_valid_i) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = ld_wd;
                    wdata_nxt = align(ld_type, ld_lsb, dresp_data_i);
                    state_nxt = S_IDLE;
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (cnt == TO_W'(TIMEOUT - 1)) begin
                    state_nxt   = S_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                end
`endif
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign stallreq_o = (state == S_WAIT);

endmodule
